nvme_cq_tracker: RTL
====================

# nvme_cq_tracker

Completion-queue tracker downstream of the NVMe PCIe slave's Rx buffer write port. It snoops every Rx buffer write, recognises completion-queue entries (CQEs) for the four completion queues, checks them against the expected head slot and phase per queue, and does two things for each valid CQE:
- pushes a completion event to the command layer;
- raises a coalesced CQ-head doorbell request toward the PCIe master.

Writes that land in the data region are ignored.

## Interface
Parameters:
- ADM_CQ_NUM, 4: admin CQ depth in entries.
- IO_CQ_NUM, 8: IO CQ depth in entries.
- RX_ADDR_BITS, 10: Rx buffer word-address width.
- EVT_DEPTH, 4: completion event FIFO depth (power of two).

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  asynchronous active-low reset
- init_done  in  1  Rx buffer zeroing finished; snooping disabled while low
- rx_write_valid  in  1  highest dword of a 128-bit Rx word written this cycle
- rx_write  in  4  per-dword write enables
- rx_waddr  in  RX_ADDR_BITS  Rx word address (one word = one CQE)
- rx_wdata  in  128  Rx write data
- evt_valid  out  1  completion event available
- evt_ready  in  1  consumer accepts event
- evt_qid  out  2  queue: 0 SSD0 admin, 1 SSD0 IO, 2 SSD1 admin, 3 SSD1 IO
- evt_cid  out  16  CQE DW3[15:0]
- evt_status  out  15  CQE DW3[31:17]
- evt_sqhd  out  16  CQE DW2[15:0]; 0 if rx_write[2] low
- db_valid  out  1  CQ head doorbell request
- db_ready  in  1  doorbell accepted
- db_qid  out  2  queue for doorbell
- db_head  out  16  new CQ head index
- err_order  out  1  sticky: CQE at wrong slot
- err_overflow  out  1  sticky: event dropped because FIFO full

## Operation
- Queue regions: q0 base 0; q1 base ADM_CQ_NUM; q2 base ADM_CQ_NUM+IO_CQ_NUM; q3 base 2*ADM_CQ_NUM+IO_CQ_NUM. Each region is sized by its depth. Addresses at or above 2*(ADM_CQ_NUM+IO_CQ_NUM) are data and are ignored.
- Per-queue state: head (16 bit, reset 0), phase (reset 1), doorbell pending flag (reset 0).
- A CQE is a candidate when all of these hold: init_done, rx_write_valid, address inside a queue region, and rx_wdata[112] (phase) equals the queue's expected phase. Candidates with a stale phase are ignored silently.
- If the candidate's offset equals head, the CQE is accepted:
  - push the event;
  - head+1, wrapping to 0 at depth; the phase toggles on wrap;
  - set doorbell pending.
- If the offset differs from head: set err_order, drop the CQE, and leave the state unchanged.
- Event FIFO: push on accept. If the FIFO is full, set err_overflow and drop the event; head, phase and doorbell still update.
- Doorbell: round-robin arbiter over the pending flags, with the pointer starting at q0 and advancing past the granted queue.
  - While db_valid is high, db_qid and db_head stay stable until db_ready.
  - Coalescing: the arbiter presents the current head at grant time. A further CQE on the same queue before handshake leaves the output stable and re-sets pending, so a later request carries the newer head.
  - On the handshake, the granted queue's pending flag clears unless it was re-set that same cycle.
- Sticky errors clear only on reset.

## Timing
- Reset values: evt_valid 0, evt_cid/status/sqhd/qid 0, db_valid 0, db_qid 0, db_head 0, err_* 0; FIFO empty, all heads 0, all phases 1.
- Latency:
  - CQE write cycle N: evt_valid high at N+1 if the FIFO was empty; state updated at N+1.
  - Pending set at N+1; db_valid high at N+2 at the earliest.
- Event interface: valid/ready, with first-word-fall-through outputs. A push and a pop in the same cycle on a full FIFO is allowed; the push is not dropped.
- One CQE per cycle maximum; back-to-back CQEs to any mix of queues are accepted every cycle.
- Reset asserted mid-transfer clears everything immediately, including a pending doorbell that has not yet handshaken.

## Structure
- The queue depths, base offsets, queue-id encoding and CQE field offsets belong in the shared nvme_defines package, next to the existing SQ/CQ constants.
- Sub-module nvme_evt_fifo: synchronous FWFT FIFO, 2+16+15+16 bits wide, EVT_DEPTH deep.

## Test plan
- After reset with init_done=1: write a phase-1 CQE with cid 0x0012 to addr 0 -> evt q0 cid 0x12; then db_valid with qid 0, head 1.
- Write 4 sequential CQEs to q0 (addr 0..3), then a phase-0 CQE at addr 0 -> 5 events; head wraps to 1 with phase 0; the final doorbell shows head 1.
- Write q1 slot 0 while db_ready is held low, then write slots 1 and 2 -> first db_head=1; the next request has db_head=3; only 2 doorbells in total.
- Write a CQE to q3 offset 2 while head is 0 -> no event, err_order=1, head unchanged.
- Hold evt_ready=0 and write 5 CQEs -> 4 events are held, err_overflow=1, doorbell head=5.
- Write to a data-region address, and write while init_done=0 -> no event, no doorbell, no error.

Source files
------------

// File: rtl/nvme_defines.sv
// Shared NVMe constants: queue depths, completion-queue layout in the Rx buffer,
// queue-id encoding and CQE field offsets.
package nvme_defines;

  localparam int ADM_SQ_DEPTH = 4;
  localparam int IO_SQ_DEPTH  = 8;
  localparam int CQ_ADM_DEPTH = 4;
  localparam int CQ_IO_DEPTH  = 8;
  localparam int CQ_COUNT     = 4;

  typedef enum logic [1:0] {
    QID_SSD0_ADM = 2'd0,
    QID_SSD0_IO  = 2'd1,
    QID_SSD1_ADM = 2'd2,
    QID_SSD1_IO  = 2'd3
  } cq_qid_e;

  // Bit positions inside a 128-bit CQE word (DW2 = [95:64], DW3 = [127:96]).
  localparam int CQE_SQHD_LSB   = 64;
  localparam int CQE_CID_LSB    = 96;
  localparam int CQE_PHASE_BIT  = 112;
  localparam int CQE_STATUS_LSB = 113;

  typedef struct packed {
    logic [1:0]  qid;
    logic [15:0] cid;
    logic [14:0] status;
    logic [15:0] sqhd;
  } cq_evt_t;

  localparam int CQ_EVT_W = $bits(cq_evt_t);

  function automatic int cq_base(input logic [1:0] qid, input int adm, input int io);
    case (qid)
      2'd0:    return 0;
      2'd1:    return adm;
      2'd2:    return adm + io;
      2'd3:    return 2 * adm + io;
      default: return 0;
    endcase
  endfunction

  function automatic int cq_depth(input logic [1:0] qid, input int adm, input int io);
    return qid[0] ? io : adm;
  endfunction

endpackage

// File: rtl/nvme_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for completion events.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module nvme_evt_fifo
  import nvme_defines::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CQ_EVT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         valid,
  input  logic         pop,
  output logic [W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         empty_s;
  logic         full_s;
  logic         do_pop_s;
  logic         do_push_s;

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);

  assign full  = full_s;
  assign valid = !empty_s;
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointers; storage is cleared so outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/nvme_cq_tracker.sv
// Snoops Rx buffer writes for CQEs of four completion queues, tracks head/phase per
// queue, queues completion events and raises coalesced CQ-head doorbell requests.
module nvme_cq_tracker
  import nvme_defines::*;
#(
  parameter int ADM_CQ_NUM   = CQ_ADM_DEPTH,
  parameter int IO_CQ_NUM    = CQ_IO_DEPTH,
  parameter int RX_ADDR_BITS = 10,
  parameter int EVT_DEPTH    = 4
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    init_done,
  input  logic                    rx_write_valid,
  input  logic [3:0]              rx_write,
  input  logic [RX_ADDR_BITS-1:0] rx_waddr,
  input  logic [127:0]            rx_wdata,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [1:0]              evt_qid,
  output logic [15:0]             evt_cid,
  output logic [14:0]             evt_status,
  output logic [15:0]             evt_sqhd,
  output logic                    db_valid,
  input  logic                    db_ready,
  output logic [1:0]              db_qid,
  output logic [15:0]             db_head,
  output logic                    err_order,
  output logic                    err_overflow
);

  localparam int BASE1    = cq_base(2'd1, ADM_CQ_NUM, IO_CQ_NUM);
  localparam int BASE2    = cq_base(2'd2, ADM_CQ_NUM, IO_CQ_NUM);
  localparam int BASE3    = cq_base(2'd3, ADM_CQ_NUM, IO_CQ_NUM);
  localparam int DATA_LO  = 2 * (ADM_CQ_NUM + IO_CQ_NUM);

  logic [31:0]   addr_s;
  logic          hit_s;
  logic [1:0]    qid_s;
  logic [15:0]   off_s;
  logic [15:0]   depth_s;
  logic [15:0]   head_cur_s;
  logic [15:0]   head_inc_s;
  logic [15:0]   head_nxt_s;
  logic          wrap_s;
  logic          cand_s;
  logic          accept_s;
  logic          order_s;
  logic          overflow_s;
  logic          fifo_full_s;
  cq_evt_t       evt_in_s;
  cq_evt_t       evt_out_s;

  logic [15:0]   head_r [CQ_COUNT];
  logic [3:0]    phase_r;
  logic [3:0]    pend_r;
  logic [1:0]    rr_ptr_r;
  logic          db_valid_r;
  logic [1:0]    db_qid_r;
  logic [15:0]   db_head_r;
  logic          err_order_r;
  logic          err_overflow_r;

  logic [7:0]    pend_dbl_s;
  logic [3:0]    pend_rot_s;
  logic [1:0]    gnt_off_s;
  logic [1:0]    gnt_qid_s;
  logic          grant_s;
  logic          unused_s;

  assign addr_s   = 32'(rx_waddr);
  assign unused_s = ^{rx_write[3], rx_write[1:0], rx_wdata[95:80], rx_wdata[63:0]};

  // Address decode: which queue region, and the slot offset inside it.
  always_comb begin
    hit_s = 1'b0;
    qid_s = 2'd0;
    off_s = 16'd0;
    if (addr_s < 32'(BASE1)) begin
      hit_s = 1'b1;
      qid_s = 2'd0;
      off_s = 16'(addr_s);
    end else if (addr_s < 32'(BASE2)) begin
      hit_s = 1'b1;
      qid_s = 2'd1;
      off_s = 16'(addr_s - 32'(BASE1));
    end else if (addr_s < 32'(BASE3)) begin
      hit_s = 1'b1;
      qid_s = 2'd2;
      off_s = 16'(addr_s - 32'(BASE2));
    end else if (addr_s < 32'(DATA_LO)) begin
      hit_s = 1'b1;
      qid_s = 2'd3;
      off_s = 16'(addr_s - 32'(BASE3));
    end else begin
      hit_s = 1'b0;
    end
  end

  assign depth_s    = qid_s[0] ? 16'(IO_CQ_NUM) : 16'(ADM_CQ_NUM);
  assign head_cur_s = head_r[qid_s];
  assign head_inc_s = head_cur_s + 16'd1;
  assign wrap_s     = (head_inc_s == depth_s);
  assign head_nxt_s = wrap_s ? 16'd0 : head_inc_s;

  // Stale-phase writes are simply not candidates; wrong-slot candidates are errors.
  assign cand_s   = init_done && rx_write_valid && hit_s &&
                    (rx_wdata[CQE_PHASE_BIT] == phase_r[qid_s]);
  assign accept_s = cand_s && (off_s == head_cur_s);
  assign order_s  = cand_s && (off_s != head_cur_s);

  assign evt_in_s.qid    = qid_s;
  assign evt_in_s.cid    = rx_wdata[CQE_CID_LSB +: 16];
  assign evt_in_s.status = rx_wdata[CQE_STATUS_LSB +: 15];
  assign evt_in_s.sqhd   = rx_write[2] ? rx_wdata[CQE_SQHD_LSB +: 16] : 16'd0;

  assign overflow_s = accept_s && fifo_full_s && !(evt_valid && evt_ready);

  nvme_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .W     (CQ_EVT_W)
  ) u_evt_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .push  (accept_s),
    .wdata (evt_in_s),
    .full  (fifo_full_s),
    .valid (evt_valid),
    .pop   (evt_ready),
    .rdata (evt_out_s)
  );

  assign evt_qid    = evt_out_s.qid;
  assign evt_cid    = evt_out_s.cid;
  assign evt_status = evt_out_s.status;
  assign evt_sqhd   = evt_out_s.sqhd;

  // Round-robin pick: rotate pending flags so the pointer position is bit 0.
  always_comb begin
    pend_dbl_s = {pend_r, pend_r} >> rr_ptr_r;
    pend_rot_s = pend_dbl_s[3:0];
    if (pend_rot_s[0]) begin
      gnt_off_s = 2'd0;
    end else if (pend_rot_s[1]) begin
      gnt_off_s = 2'd1;
    end else if (pend_rot_s[2]) begin
      gnt_off_s = 2'd2;
    end else begin
      gnt_off_s = 2'd3;
    end
    gnt_qid_s = rr_ptr_r + gnt_off_s;
    grant_s   = (|pend_r) && !db_valid_r;
  end

  // Per-queue head, phase and doorbell-pending state.
  // Pending is consumed at grant; a CQE arriving at or after grant re-arms it, so the
  // presented head stays stable and a later request carries the newer head.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int q = 0; q < CQ_COUNT; q++) begin
        head_r[q] <= 16'd0;
      end
      phase_r <= 4'hF;
      pend_r  <= 4'h0;
    end else begin
      for (int q = 0; q < CQ_COUNT; q++) begin
        if (accept_s && (qid_s == 2'(q))) begin
          head_r[q] <= head_nxt_s;
          if (wrap_s) begin
            phase_r[q] <= ~phase_r[q];
          end
          pend_r[q] <= 1'b1;
        end else if (grant_s && (gnt_qid_s == 2'(q))) begin
          pend_r[q] <= 1'b0;
        end
      end
    end
  end

  // Doorbell request register; fields hold stable from grant until handshake.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      db_valid_r <= 1'b0;
      db_qid_r   <= 2'd0;
      db_head_r  <= 16'd0;
      rr_ptr_r   <= 2'd0;
    end else if (grant_s) begin
      db_valid_r <= 1'b1;
      db_qid_r   <= gnt_qid_s;
      db_head_r  <= head_r[gnt_qid_s];
      rr_ptr_r   <= gnt_qid_s + 2'd1;
    end else if (db_valid_r && db_ready) begin
      db_valid_r <= 1'b0;
    end
  end

  // Sticky error flags.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      err_order_r    <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      if (order_s) begin
        err_order_r <= 1'b1;
      end
      if (overflow_s) begin
        err_overflow_r <= 1'b1;
      end
    end
  end

  assign db_valid     = db_valid_r;
  assign db_qid       = db_qid_r;
  assign db_head      = db_head_r;
  assign err_order    = err_order_r;
  assign err_overflow = err_overflow_r;

endmodule
